// File: rtl/washer_actuator_driver.sv
// Plant-side actuator driver: decodes washer cycle state and water command into
// valve, motor and door-lock drives and times each phase. Optional: WASHER_FILL_FAULT_EN.
module washer_actuator_driver #(
  parameter int TIMER_W      = 16,
  parameter int AGITATE_HALF = 16,
  parameter int AGITATE_REVS = 8,
  parameter int SPIN_CYCLES  = 64,
  parameter int FILL_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state_in,
  input  logic [1:0] water_in,
  input  logic       door,
  input  logic       level_full,
  output logic       hot_valve,
  output logic       cold_valve,
  output logic       motor_en,
  output logic       motor_dir,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       step_done,
  output logic       fault
);

  typedef enum logic [2:0] {
    P_IDLE,
    P_FILL,
    P_AGITATE,
    P_SPIN,
    P_DONE,
    P_FAULT
  } phase_t;

  localparam int REV_W = $clog2(AGITATE_REVS + 1);

  phase_t             phase_q, phase_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [REV_W-1:0]   revs_q, revs_d;
  logic               dir_q, dir_d;
  logic [2:0]         prev_q;
  logic               first_q;
  logic               restart;

  logic hot_d, cold_d, en_d, dir_out_d, fast_d, lock_d, done_d, fault_d;

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign restart = first_q || (state_in != prev_q);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    phase_d   = phase_q;
    timer_d   = timer_q;
    revs_d    = revs_q;
    dir_d     = dir_q;
    hot_d     = 1'b0;
    cold_d    = 1'b0;
    en_d      = 1'b0;
    dir_out_d = 1'b0;
    fast_d    = 1'b0;
    done_d    = 1'b0;
    lock_d    = (state_in >= 3'd2) && !door;
`ifdef WASHER_FILL_FAULT_EN
    fault_d   = fault;
`else
    fault_d   = 1'b0;
`endif

    if (restart) begin
      // A new command always starts its phase from scratch and never reports completion.
      timer_d = '0;
      revs_d  = '0;
      dir_d   = 1'b0;
      unique case (state_in)
        3'd2, 3'd5: phase_d = P_FILL;
        3'd3, 3'd6: phase_d = P_AGITATE;
        3'd4, 3'd7: phase_d = P_SPIN;
        default: begin
          phase_d = P_IDLE;
          fault_d = 1'b0;
        end
      endcase
    end else begin
      unique case (phase_q)
        P_FILL: begin
          if (!door) begin
            if (level_full) begin
              done_d  = 1'b1;
              phase_d = P_DONE;
            end
`ifdef WASHER_FILL_FAULT_EN
            else if (timer_q >= TIMER_W'(FILL_TIMEOUT)) begin
              fault_d = 1'b1;
              phase_d = P_FAULT;
            end
`endif
            else begin
              hot_d   = water_in[1];
              cold_d  = water_in[0];
              timer_d = sat_inc(timer_q);
            end
          end
        end

        P_AGITATE: begin
          if (revs_q == REV_W'(AGITATE_REVS)) begin
            done_d  = 1'b1;
            phase_d = P_DONE;
          end else begin
            // Direction is held while the door is open so agitation resumes where it stopped.
            dir_out_d = dir_q;
            if (!door) begin
              en_d = 1'b1;
              if (timer_q == TIMER_W'(AGITATE_HALF - 1)) begin
                timer_d = '0;
                dir_d   = ~dir_q;
                revs_d  = revs_q + 1'b1;
              end else begin
                timer_d = sat_inc(timer_q);
              end
            end
          end
        end

        P_SPIN: begin
          if (timer_q >= TIMER_W'(SPIN_CYCLES)) begin
            done_d  = 1'b1;
            phase_d = P_DONE;
          end else if (!door) begin
            en_d    = 1'b1;
            fast_d  = 1'b1;
            timer_d = sat_inc(timer_q);
          end
        end

        default: ;  // P_IDLE, P_DONE, P_FAULT: drives stay off until the command changes
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= P_IDLE;
      timer_q    <= '0;
      revs_q     <= '0;
      dir_q      <= 1'b0;
      prev_q     <= 3'd0;
      first_q    <= 1'b1;
      hot_valve  <= 1'b0;
      cold_valve <= 1'b0;
      motor_en   <= 1'b0;
      motor_dir  <= 1'b0;
      motor_fast <= 1'b0;
      door_lock  <= 1'b0;
      step_done  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      revs_q     <= revs_d;
      dir_q      <= dir_d;
      prev_q     <= state_in;
      first_q    <= 1'b0;
      hot_valve  <= hot_d;
      cold_valve <= cold_d;
      motor_en   <= en_d;
      motor_dir  <= dir_out_d;
      motor_fast <= fast_d;
      door_lock  <= lock_d;
      step_done  <= done_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_washer_actuator_driver.sv
// Directed self-checking bench for washer_actuator_driver; output vector order is
// {hot_valve, cold_valve, motor_en, motor_dir, motor_fast, door_lock, step_done, fault}.
module tb_washer_actuator_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_in;
  logic [1:0] water_in;
  logic       door;
  logic       level_full;
  logic       hot_valve, cold_valve, motor_en, motor_dir, motor_fast;
  logic       door_lock, step_done, fault;
  logic [7:0] outs;

  int errors = 0;
  int checks = 0;

  washer_actuator_driver dut (
    .clk        (clk),
    .rst        (rst),
    .state_in   (state_in),
    .water_in   (water_in),
    .door       (door),
    .level_full (level_full),
    .hot_valve  (hot_valve),
    .cold_valve (cold_valve),
    .motor_en   (motor_en),
    .motor_dir  (motor_dir),
    .motor_fast (motor_fast),
    .door_lock  (door_lock),
    .step_done  (step_done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  assign outs = {hot_valve, cold_valve, motor_en, motor_dir, motor_fast,
                 door_lock, step_done, fault};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; state_in = 3'd1; water_in = 2'b00; door = 1'b0; level_full = 1'b0;
    tick();
    tick();
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++; $display("FAIL reset_hold: got %b want %b", outs, 8'b0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++; $display("FAIL reset_idle: got %b want %b", outs, 8'b0);
    end
  endtask

  task automatic test_fill();
    state_in = 3'd2; water_in = 2'b10; level_full = 1'b0;
    tick();
    checks++;
    if (outs !== 8'b0000_0100) begin
      errors++; $display("FAIL fill_entry: got %b want %b", outs, 8'b0000_0100);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (outs !== 8'b1000_0100) begin
        errors++; $display("FAIL fill_hot c%0d: got %b want %b", k, outs, 8'b1000_0100);
      end
    end
    level_full = 1'b1;
    tick();
    checks++;
    if (outs !== 8'b0000_0110) begin
      errors++; $display("FAIL fill_done: got %b want %b", outs, 8'b0000_0110);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (outs !== 8'b0000_0100) begin
        errors++; $display("FAIL fill_after c%0d: got %b want %b", k, outs, 8'b0000_0100);
      end
    end
  endtask

  task automatic test_fill_already_full();
    state_in = 3'd5; water_in = 2'b11; level_full = 1'b1;
    tick();
    checks++;
    if (outs !== 8'b0000_0100) begin
      errors++; $display("FAIL full_entry: got %b want %b", outs, 8'b0000_0100);
    end
    tick();
    checks++;
    if (outs !== 8'b0000_0110) begin
      errors++; $display("FAIL full_done: got %b want %b", outs, 8'b0000_0110);
    end
    tick();
    checks++;
    if (outs !== 8'b0000_0100) begin
      errors++; $display("FAIL full_after: got %b want %b", outs, 8'b0000_0100);
    end
    level_full = 1'b0;
  endtask

  task automatic test_agitate();
    logic [7:0] exp;
    state_in = 3'd3; door = 1'b0;
    tick();
    checks++;
    if (outs !== 8'b0000_0100) begin
      errors++; $display("FAIL agit_entry: got %b want %b", outs, 8'b0000_0100);
    end
    for (int k = 1; k <= 128; k++) begin
      tick();
      exp = {2'b00, 1'b1, 1'(((k - 1) / 16) % 2), 4'b0100};
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL agit_run c%0d: got %b want %b", k, outs, exp);
      end
    end
    tick();
    checks++;
    if (outs !== 8'b0000_0110) begin
      errors++; $display("FAIL agit_done: got %b want %b", outs, 8'b0000_0110);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (outs !== 8'b0000_0100) begin
        errors++; $display("FAIL agit_hold c%0d: got %b want %b", k, outs, 8'b0000_0100);
      end
    end
  endtask

  task automatic test_spin_door();
    logic [7:0] exp;
    state_in = 3'd4; door = 1'b0;
    tick();
    for (int c = 0; c < 69; c++) begin
      if (c == 20) door = 1'b1;
      if (c == 25) door = 1'b0;
      tick();
      exp = (c >= 20 && c < 25) ? 8'b0000_0000 : 8'b0010_1100;
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL spin c%0d: got %b want %b", c, outs, exp);
      end
    end
    tick();
    checks++;
    if (outs !== 8'b0000_0110) begin
      errors++; $display("FAIL spin_done c69: got %b want %b", outs, 8'b0000_0110);
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    state_in = 3'd3;
    tick();
    for (int c = 0; c < 40; c++) begin
      tick();
      exp = {2'b00, 1'b1, 1'((c / 16) % 2), 4'b0100};
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL abort_agit c%0d: got %b want %b", c, outs, exp);
      end
    end
    state_in = 3'd4;
    tick();
    checks++;
    if (outs !== 8'b0000_0100) begin
      errors++; $display("FAIL abort_restart: got %b want %b", outs, 8'b0000_0100);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (outs !== 8'b0010_1100) begin
        errors++; $display("FAIL abort_spin c%0d: got %b want %b", c, outs, 8'b0010_1100);
      end
    end
  endtask

`ifdef WASHER_FILL_FAULT_EN
  task automatic test_fill_fault();
    state_in = 3'd5; water_in = 2'b01; level_full = 1'b0; door = 1'b0;
    tick();
    for (int k = 1; k <= 255; k++) begin
      tick();
      checks++;
      if (outs !== 8'b0100_0100) begin
        errors++; $display("FAIL fault_fill c%0d: got %b want %b", k, outs, 8'b0100_0100);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (outs !== 8'b0000_0101) begin
        errors++; $display("FAIL fault_set c%0d: got %b want %b", k, outs, 8'b0000_0101);
      end
    end
    state_in = 3'd1;
    tick();
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++; $display("FAIL fault_clear: got %b want %b", outs, 8'b0);
    end
  endtask
`else
  task automatic test_fill_fault();
    state_in = 3'd5; water_in = 2'b01; level_full = 1'b0; door = 1'b0;
    tick();
    for (int k = 1; k <= 300; k++) begin
      tick();
      checks++;
      if (outs !== 8'b0100_0100) begin
        errors++; $display("FAIL fill_wait c%0d: got %b want %b", k, outs, 8'b0100_0100);
      end
    end
    state_in = 3'd1;
    tick();
    checks++;
    if (outs !== 8'b0000_0000) begin
      errors++; $display("FAIL fill_wait_idle: got %b want %b", outs, 8'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_fill_already_full();
    test_agitate();
    test_spin_door();
    test_abort();
    test_fill_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
